// File: rtl/riot_bus_master_pkg.sv
// Shared definitions for the RIOT peripheral bus master: FSM states, command
// opcodes, bus select codes and the interrupt-flag register address.
package riot_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WAIT_IRQ = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  localparam logic [1:0] CS_IDLE       = 2'b00;
  localparam logic [1:0] CS_SEL        = 2'b01;
  localparam logic [6:0] IRQ_FLAG_ADDR = 7'h05;

  function automatic logic is_write(input op_t op);
    return op == OP_WRITE;
  endfunction

endpackage

// File: rtl/riot_bus_master_poll_timer.sv
// Cycle counter for the WAIT_IRQ state: clears outside the state, counts while
// enabled, and flags the cycle on which the count reaches LIMIT.
module riot_poll_timer #(
  parameter logic [15:0] LIMIT = 16'hFFFF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted on the edge where this cycle's increment reaches LIMIT.
  assign limit_o = en_i && (count_q == LIMIT - 16'd1);

endmodule

// File: rtl/riot_bus_master.sv
// Command/response front end that runs single read/write accesses and IRQ polls
// on a RIOT-style peripheral bus; all bus pins come straight from registers.
module riot_bus_master
  import riot_bus_master_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] POLL_LIMIT  = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic       CMD_RAM,
  input  logic [6:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic       R_W,
  output logic [1:0] CS,
  output logic       RS_N,
  output logic [6:0] A,
  output logic [7:0] D_OUT,
  input  logic [7:0] D_IN,
  input  logic       IRQ_N
);

  state_t     state_q;
  op_t        op_q;
  logic       ram_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic [3:0] hold_q;

  logic       rw_q;
  logic [1:0] cs_q;
  logic       rsn_q;
  logic [6:0] a_q;
  logic [7:0] dout_q;

  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;

  logic       poll_limit;

  riot_poll_timer #(
    .LIMIT(POLL_LIMIT)
  ) u_poll_timer (
    .clk_i  (CLK),
    .rst_ni (RES_N),
    .clr_i  (state_q != ST_WAIT_IRQ),
    .en_i   (state_q == ST_WAIT_IRQ),
    .limit_o(poll_limit)
  );

  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      ram_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hold_q      <= '0;
      rw_q        <= 1'b1;
      cs_q        <= CS_IDLE;
      rsn_q       <= 1'b1;
      a_q         <= '0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (CMD_VALID) begin
            op_q    <= op_t'(CMD_OP);
            ram_q   <= CMD_RAM;
            addr_q  <= CMD_ADDR;
            wdata_q <= CMD_WDATA;
            case (op_t'(CMD_OP))
              OP_READ, OP_WRITE: state_q <= ST_SETUP;
              OP_POLL:           state_q <= ST_WAIT_IRQ;
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_data_q  <= '0;
                state_q     <= ST_RESP;
              end
            endcase
          end
        end
        // Bus registers load here, so the pins show the setup beat one cycle
        // later; HOLD therefore runs WAIT_CYCLES+1 cycles to cover setup+hold.
        ST_SETUP: begin
          cs_q    <= CS_SEL;
          rsn_q   <= ~ram_q;
          a_q     <= addr_q;
          rw_q    <= ~is_write(op_q);
          dout_q  <= is_write(op_q) ? wdata_q : 8'h00;
          hold_q  <= 4'(WAIT_CYCLES);
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_q == 4'd0) begin
            rsp_data_q  <= is_write(op_q) ? 8'h00 : D_IN;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            cs_q        <= CS_IDLE;
            rw_q        <= 1'b1;
            rsn_q       <= 1'b1;
            a_q         <= '0;
            dout_q      <= '0;
            state_q     <= ST_RESP;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        ST_WAIT_IRQ: begin
          // An interrupt seen on the limit cycle still gets serviced.
          if (!IRQ_N) begin
            op_q    <= OP_READ;
            ram_q   <= 1'b0;
            addr_q  <= IRQ_FLAG_ADDR;
            state_q <= ST_SETUP;
          end else if (poll_limit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign R_W       = rw_q;
  assign CS        = cs_q;
  assign RS_N      = rsn_q;
  assign A         = a_q;
  assign D_OUT     = dout_q;

endmodule
